mem_arbiter: RTL and testbench

//   Shares the single-port 4KB Memory between the CPU fetch port (IF) and the data port (D).
//   - Arbitrates between the two requesters.
//   - Drives Memory's address bus, write mode and bidirectional 16-bit data bus.
//   - Returns read data with a one-cycle ack pulse.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port 4KB memory between the instruction-fetch
//            port (IF) and the data port (D). Round-robin arbitration when
//            both requesters are pending, word-aligned memory addressing, a
//            one-cycle ack pulse per access and registered read data.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            if_req/if_addr      - fetch read request (level, held to ack)
//            if_rdata/if_ack     - fetch read data and completion pulse
//            d_req/d_we/d_addr/d_wdata - data request (read or write)
//            d_rdata/d_ack       - data read data and completion pulse
//            err                 - protection violation pulse
//            mem_addr/mem_we/mem_data - memory address, write mode, data bus
// Config   : MEM_ARB_PROTECT_EN - when defined, rejects IF accesses outside
//            module 0 and D writes into module 0 (ack + err, no access).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                gnt_d;      // 1 = current access belongs to D
  logic                last_d;     // 1 = previous grant went to D
  logic                acc_we;
  logic [DATA_W-1:0]   acc_wdata;
  logic [CNT_W-1:0]    cnt;

  logic any_req, pick_d, req_rej;
  logic unused_addr_lsb;

  // Byte address bit 0 never reaches memory: accesses are word-aligned.
  assign unused_addr_lsb = ^{if_addr[0], d_addr[0]};

  assign any_req = if_req | d_req;
  // Lone requester wins; with both pending, the one not served last wins.
  // last_d resets to 1 so the first contested grant goes to IF.
  assign pick_d  = d_req & (~if_req | ~last_d);

`ifdef MEM_ARB_PROTECT_EN
  logic rej;
  assign req_rej = pick_d ? (d_we && (d_addr[ADDR_W-1:ADDR_W-2] == 2'b00))
                          : (if_addr[ADDR_W-1:ADDR_W-2] != 2'b00);
`else
  assign req_rej = 1'b0;
`endif

  // State register and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_d     <= 1'b0;
      last_d    <= 1'b1;
      acc_we    <= 1'b0;
      acc_wdata <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
`ifdef MEM_ARB_PROTECT_EN
      rej       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_d     <= pick_d;
            last_d    <= pick_d;
            mem_addr  <= {(pick_d ? d_addr[ADDR_W-1:1] : if_addr[ADDR_W-1:1]), 1'b0};
            acc_we    <= pick_d & d_we;
            acc_wdata <= d_wdata;
            cnt       <= CNT_INIT;
`ifdef MEM_ARB_PROTECT_EN
            rej       <= req_rej;
`endif
            // A rejected access completes immediately with zero read data.
            if (req_rej) begin
              if (pick_d) d_rdata  <= '0;
              else        if_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!acc_we) begin
              if (gnt_d) d_rdata  <= mem_data;
              else       if_rdata <= mem_data;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = req_rej ? DONE : ACCESS;
      end
      ACCESS: begin
        mem_we = acc_we;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        if_ack    = ~gnt_d;
        d_ack     = gnt_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_ARB_PROTECT_EN
  assign err = (state == DONE) & rej;
`else
  assign err = 1'b0;
`endif

  // Bus is driven only while writing; state resets asynchronously, so rst
  // releases the bus immediately.
  assign mem_data = mem_we ? acc_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A transaction-level model
//            tracks each access by the number of cycles since its grant and
//            predicts acks, memory bus activity and read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          if_ack, d_ack, err, mem_we;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] env_mem   [0:2047];
  logic [DW-1:0] model_mem [0:2047];

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory: drives the bus whenever it is not in write mode.
  assign mem_data = mem_we ? {DW{1'bz}} : env_mem[mem_addr[AW-1:1]];
  always @(posedge clk) if (mem_we) env_mem[mem_addr[AW-1:1]] <= mem_data;

  // ---------------- reference model ----------------
  int            ph;          // -1 idle, else cycles since grant
  bit            m_gd, m_last_d, m_we, m_rej;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;

  function automatic bit prot_rej(bit is_d, bit we, logic [AW-1:0] a);
`ifdef MEM_ARB_PROTECT_EN
    return is_d ? (we && a[AW-1:AW-2] == 2'b00) : (a[AW-1:AW-2] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    ph = -1; m_gd = 0; m_last_d = 1; m_we = 0; m_rej = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
  endtask

  task automatic model_edge();
    logic [AW-1:0] a;
    bit pd;
    if (ph < 0) begin
      if (if_req || d_req) begin
        // both pending: serve whichever was not served last
        pd = (if_req && d_req) ? !m_last_d : d_req;
        m_gd = pd; m_last_d = pd;
        a = pd ? d_addr : if_addr;
        m_rej = prot_rej(pd, d_we, a);
        a[0] = 1'b0;
        m_addr = a; m_we = pd && d_we; m_wdata = d_wdata;
        if (m_rej) begin
          ph = LAT;
          if (pd) m_d_rdata = '0; else m_if_rdata = '0;
        end else ph = 0;
      end
    end else if (ph < LAT) begin
      ph++;
      if (ph == LAT) begin
        if (m_we)      model_mem[m_addr[AW-1:1]] = m_wdata;
        else if (m_gd) m_d_rdata  = model_mem[m_addr[AW-1:1]];
        else           m_if_rdata = model_mem[m_addr[AW-1:1]];
      end
    end else ph = -1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    bit done, wr, exp_err;
    done = (ph == LAT);
    wr   = (ph >= 0) && (ph < LAT) && m_we && !m_rej;
`ifdef MEM_ARB_PROTECT_EN
    exp_err = done && m_rej;
`else
    exp_err = 1'b0;
`endif
    check("if_ack",   32'(if_ack),   32'(done && !m_gd));
    check("d_ack",    32'(d_ack),    32'(done && m_gd));
    check("err",      32'(err),      32'(exp_err));
    check("mem_we",   32'(mem_we),   32'(wr));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_data", 32'(mem_data), 32'(wr ? m_wdata : model_mem[m_addr[AW-1:1]]));
    check("if_rdata", 32'(if_rdata), 32'(m_if_rdata));
    check("d_rdata",  32'(d_rdata),  32'(m_d_rdata));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    cmp_all();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] v;
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 2048; i++) begin
      v = DW'($urandom);
      env_mem[i] = v; model_mem[i] = v;
    end
    env_mem[8] = 16'h1234; model_mem[8] = 16'h1234;

    // 1. reset state
    do_reset();
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);

    // 2. D write to odd address: word-aligned, bus driven for LAT cycles
    d_req = 1; d_we = 1; d_addr = 12'h403; d_wdata = 16'hBEEF;
    step();
    check("wr_addr", 32'(mem_addr), 32'h402);
    check("wr_we",   32'(mem_we),   32'd1);
    check("wr_data", 32'(mem_data), 32'hBEEF);
    for (int i = 1; i < LAT; i++) step();
    step();
    check("wr_ack", 32'(d_ack), 32'd1);
    d_req = 0; d_we = 0;
    step();
    check("wr_ack_pulse", 32'(d_ack), 32'd0);

    // 3. IF read of 0x010, data held afterwards
    if_req = 1; if_addr = 12'h010;
    step();
    check("rd_we", 32'(mem_we), 32'd0);
    for (int i = 1; i < LAT; i++) step();
    step();
    check("rd_ack",   32'(if_ack),   32'd1);
    check("rd_rdata", 32'(if_rdata), 32'h1234);
    if_req = 0;
    step(); step();
    check("rd_hold", 32'(if_rdata), 32'h1234);

    // 4. both requests held from reset: IF, D, IF, D, one per LAT+2 cycles
    do_reset();
    if_req = 1; if_addr = 12'h020; d_req = 1; d_we = 0; d_addr = 12'h510;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i <= LAT; i++) step();
      check("rr_if_ack", 32'(if_ack), 32'(k % 2 == 0));
      check("rr_d_ack",  32'(d_ack),  32'(k % 2 == 1));
      step();
      check("rr_gap", 32'(if_ack | d_ack), 32'd0);
    end
    if_req = 0; d_req = 0;
    step();

    // 5. reset during a write access: bus released at once, no ack
    d_req = 1; d_we = 1; d_addr = 12'h406; d_wdata = 16'hA5A5;
    step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("abort_we",  32'(mem_we), 32'd0);
    check("abort_ack", 32'(d_ack),  32'd0);
    cmp_all();
    d_req = 0; d_we = 0;
    step();
    rst = 1'b0;
    step();
    check("abort_no_ack", 32'(d_ack), 32'd0);

    // 6. D write into module 0
    d_req = 1; d_we = 1; d_addr = 12'h004; d_wdata = 16'h5A5A;
    step();
    for (int i = 1; i < LAT; i++) if (ph != LAT) step();
    if (ph != LAT) step();
`ifdef MEM_ARB_PROTECT_EN
    check("prot_err", 32'(err), 32'd1);
`else
    check("prot_err", 32'(err), 32'd0);
`endif
    check("prot_ack", 32'(d_ack), 32'd1);
    d_req = 0; d_we = 0;
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (if_ack) if_req = 0;
      if (d_ack)  d_req  = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1;
        if_addr = {($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, 10'($urandom)};
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1;
        d_we    = 1'($urandom);
        d_addr  = AW'($urandom);
        d_wdata = DW'($urandom);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
